bcd_to_excess3: RTL and testbench
=================================

// Module: bcd_to_excess3
// PURPOSE
//  Registered BCD-to-Excess-3 code converter for DIGITS packed BCD digits.
//  Each 4-bit BCD nibble (0..9) is mapped to its Excess-3 code (value + 3).
//  Sits between a BCD source (counter, keypad decoder) and Excess-3 consumers
//  such as self-complementing adders or display logic. One-cycle pipeline.
// PARAMETERS
//  DIGITS  1  number of packed BCD digits converted in parallel (>=1)
// PORTS
//  clk        in   1         single system clock, rising-edge
//  rst        in   1         asynchronous, active-high reset
//  in_valid   in   1         bcd is valid this cycle; capture and convert
//  bcd        in   4*DIGITS  packed BCD input; digit k at bcd[4k+3:4k]
//  out_valid  out  1         ex3/err hold the result of a captured input
//  ex3        out  4*DIGITS  packed Excess-3 output; digit k at ex3[4k+3:4k]
//  err        out  1         at least one captured nibble was > 9
//  err_mask   out  DIGITS    per-digit flag: bit k = nibble k was > 9
// BEHAVIOUR
//  - Clock and reset: all state on posedge clk; rst asserted clears
//    immediately (asynchronous), regardless of clk.
//  - Reset values: out_valid=0, ex3=0, err=0, err_mask=0.
//  - Latency: exactly 1 cycle. in_valid=1 at edge N -> out_valid=1 and
//    results visible after edge N.
//  - in_valid=0 at an edge: out_valid<=0; ex3, err, err_mask hold last values.
//  - Back-to-back: in_valid may stay high every cycle; one result per cycle.
//  - Per-digit mapping (4-bit, no carry between digits):
//    0->0011 1->0100 2->0101 3->0110 4->0111 5->1000 6->1001 7->1010
//    8->1011 9->1100.
//  - Invalid nibble (1010..1111): that ex3 nibble <= 0000, err_mask[k] <= 1;
//    other digits convert normally. err = OR of err_mask.
//  - Outputs are registered only; no combinational path from bcd to ex3.
//  - rst asserted mid-stream: any captured result is discarded; out_valid
//    stays 0 until the first in_valid edge after rst deasserts.
//  - in_valid and rst both high at an edge: rst wins.
// TESTING
//  1. Reset: assert rst without clk edges -> out_valid=0, ex3=0, err=0.
//  2. DIGITS=1 sweep: bcd=0..9, in_valid=1, one per cycle -> next cycle
//     ex3=0011,0100,...,1100 in order, out_valid=1, err=0.
//  3. Invalid: bcd=4'hA then 4'hF -> ex3=0000, err=1, err_mask=1; then
//     bcd=4'h5 -> ex3=1000, err=0.
//  4. Hold: convert 4'h7 (ex3=1010), then in_valid=0 for 3 cycles ->
//     out_valid=0, ex3 remains 1010.
//  5. DIGITS=2: bcd=8'h29 -> ex3=8'h5C; bcd=8'h3B -> ex3=8'h60,
//     err_mask=2'b01, err=1.
//  6. rst pulse during streaming between edges -> outputs clear at once;
//     first in_valid after release yields correct ex3 one cycle later.

Source files
------------

// File: rtl/bcd_to_excess3.sv
// Registered packed-BCD to Excess-3 converter with a one-cycle pipeline.
// Each nibble maps independently (value + 3). A nibble above 9 yields 0000
// and raises its err_mask bit; err is the OR of all mask bits.
module bcd_to_excess3 #(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   ex3,
  output logic                  err,
  output logic [DIGITS-1:0]     err_mask
);

  logic [4*DIGITS-1:0] ex3_nxt;
  logic [DIGITS-1:0]   mask_nxt;
  logic [3:0]          nib;

  // Per-digit conversion; digits are independent, no carry between nibbles.
  always_comb begin
    ex3_nxt  = '0;
    mask_nxt = '0;
    nib      = '0;
    for (int k = 0; k < DIGITS; k++) begin
      nib = bcd[4*k +: 4];
      if (nib > 4'd9) begin
        ex3_nxt[4*k +: 4] = 4'b0000;
        mask_nxt[k]       = 1'b1;
      end else begin
        ex3_nxt[4*k +: 4] = nib + 4'd3;
      end
    end
  end

  // Output register: capture on in_valid, otherwise hold data and drop valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ex3       <= '0;
      err       <= 1'b0;
      err_mask  <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      ex3       <= ex3_nxt;
      err       <= |mask_nxt;
      err_mask  <= mask_nxt;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_to_excess3.sv
// Randomized self-checking bench: a one-digit and a two-digit instance run
// side by side against an arithmetic reference model.
module tb_bcd_to_excess3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic [3:0] b1 = '0;
  logic [7:0] b2 = '0;

  logic       ov1, ov2, er1, er2;
  logic [3:0] ex1;
  logic [7:0] ex2;
  logic [0:0] mk1;
  logic [1:0] mk2;

  // expected state of each instance
  logic       m_ov1, m_ov2, m_er1, m_er2;
  logic [3:0] m_ex1;
  logic [7:0] m_ex2;
  logic [0:0] m_mk1;
  logic [1:0] m_mk2;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_to_excess3 #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .bcd(b1),
    .out_valid(ov1), .ex3(ex1), .err(er1), .err_mask(mk1)
  );

  bcd_to_excess3 #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .bcd(b2),
    .out_valid(ov2), .ex3(ex2), .err(er2), .err_mask(mk2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int ref_ex3(input int v, input int nd);
    int r = 0;
    for (int k = 0; k < nd; k++) begin
      int d = (v >> (4 * k)) % 16;
      if (d <= 9) r += (d + 3) << (4 * k);
    end
    return r;
  endfunction

  function automatic int ref_mask(input int v, input int nd);
    int r = 0;
    for (int k = 0; k < nd; k++)
      if (((v >> (4 * k)) % 16) > 9) r += 1 << k;
    return r;
  endfunction

  task automatic model_reset();
    m_ov1 = 0; m_ov2 = 0; m_er1 = 0; m_er2 = 0;
    m_ex1 = '0; m_ex2 = '0; m_mk1 = '0; m_mk2 = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ov1"}, 32'(ov1), 32'(m_ov1));
    check({tag, ".ex1"}, 32'(ex1), 32'(m_ex1));
    check({tag, ".er1"}, 32'(er1), 32'(m_er1));
    check({tag, ".mk1"}, 32'(mk1), 32'(m_mk1));
    check({tag, ".ov2"}, 32'(ov2), 32'(m_ov2));
    check({tag, ".ex2"}, 32'(ex2), 32'(m_ex2));
    check({tag, ".er2"}, 32'(er2), 32'(m_er2));
    check({tag, ".mk2"}, 32'(mk2), 32'(m_mk2));
  endtask

  // Drive inputs (called right after a falling edge), clock once, then check.
  task automatic step(input string tag, input logic iv1, input int ib1,
                      input logic iv2, input int ib2);
    v1 = iv1; b1 = 4'(ib1);
    v2 = iv2; b2 = 8'(ib2);
    @(posedge clk);
    m_ov1 = iv1;
    if (iv1) begin
      m_ex1 = 4'(ref_ex3(ib1 % 16, 1));
      m_mk1 = 1'(ref_mask(ib1 % 16, 1));
      m_er1 = (m_mk1 != 0);
    end
    m_ov2 = iv2;
    if (iv2) begin
      m_ex2 = 8'(ref_ex3(ib2 % 256, 2));
      m_mk2 = 2'(ref_mask(ib2 % 256, 2));
      m_er2 = (m_mk2 != 0);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    // asynchronous reset with no clock edge yet
    #1 rst = 1'b1;
    #1 check_all("reset_async");
    // reset wins over in_valid at an edge
    v1 = 1'b1; b1 = 4'h5; v2 = 1'b1; b2 = 8'h12;
    @(negedge clk);
    check_all("reset_wins");
    rst = 1'b0;

    // full legal sweep on both instances
    for (int i = 0; i < 10; i++) step("sweep", 1'b1, i, 1'b1, i * 16 + (9 - i));

    // invalid nibbles, then recovery
    step("inv_a", 1'b1, 'hA, 1'b1, 'hA3);
    step("inv_f", 1'b1, 'hF, 1'b1, 'hFF);
    step("inv_ok", 1'b1, 'h5, 1'b1, 'h55);

    // hold while idle, with changing bcd
    step("hold_cap", 1'b1, 'h7, 1'b1, 'h29);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, $urandom_range(15), 1'b0, $urandom_range(255));

    // two-digit examples
    step("d2_29", 1'b1, 'h0, 1'b1, 'h29);
    step("d2_3b", 1'b1, 'h9, 1'b1, 'h3B);

    // reset pulse between edges while streaming
    step("stream", 1'b1, 'h4, 1'b1, 'h81);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("reset_mid");
    #1 rst = 1'b0;
    step("post_rst_idle", 1'b0, 'h3, 1'b0, 'h44);
    step("post_rst_cap", 1'b1, 'h3, 1'b1, 'h44);

    // randomized traffic
    for (int i = 0; i < 200; i++)
      step("rand", 1'($urandom_range(1)), $urandom_range(15),
           1'($urandom_range(1)), $urandom_range(255));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
